// File: rtl/tm1638_key_event.sv
// Per-key debounce and event generator for the 8 TM1638 raw key levels.
// A shared prescaler tick drives 8 independent per-key FSMs.

module tm1638_key_fsm #(
    parameter int C_DEB_TICKS  = 20,
    parameter int C_LONG_TICKS = 800,
    parameter int C_REP_TICKS  = 150
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clr,
    input  logic key,
    output logic lvl,
    output logic press,
    output logic rel,
    output logic lng,
    output logic rep,
    output logic tog
);
    localparam int MAX_T = (C_DEB_TICKS > C_LONG_TICKS) ?
                           ((C_DEB_TICKS > C_REP_TICKS) ? C_DEB_TICKS : C_REP_TICKS) :
                           ((C_LONG_TICKS > C_REP_TICKS) ? C_LONG_TICKS : C_REP_TICKS);
    localparam int CTR_W = (MAX_T <= 2) ? 1 : $clog2(MAX_T);

    typedef enum logic [2:0] {IDLE, DEB_ON, HELD, RPT, DEB_OFF} state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic               lvl_q, lvl_d, press_q, press_d, rel_q, rel_d;
    logic               lng_q, lng_d, rep_q, rep_d, tog_q, tog_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            lng_q   <= 1'b0;
            rep_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            lng_q   <= lng_d;
            rep_q   <= rep_d;
            tog_q   <= tog_d;
        end
    end

    // Raw-level tests come before the tick so a change on the terminal tick aborts the event.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        lng_d   = 1'b0;
        rep_d   = 1'b0;
        tog_d   = tog_q;
        if (clr) begin
            state_d = IDLE;
            ctr_d   = '0;
            tog_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key) begin
                        state_d = DEB_ON;
                        ctr_d   = '0;
                    end
                end
                DEB_ON: begin
                    if (!key) begin
                        state_d = IDLE;
                        ctr_d   = '0;
                    end else if (tick) begin
                        if (ctr_q == CTR_W'(C_DEB_TICKS - 1)) begin
                            state_d = HELD;
                            ctr_d   = '0;
                            press_d = 1'b1;
                            tog_d   = ~tog_q;
                        end else begin
                            ctr_d = ctr_q + CTR_W'(1);
                        end
                    end
                end
                HELD: begin
                    if (!key) begin
                        state_d = DEB_OFF;
                        ctr_d   = '0;
                    end else if (tick) begin
                        if (ctr_q == CTR_W'(C_LONG_TICKS - 1)) begin
                            state_d = RPT;
                            ctr_d   = '0;
                            lng_d   = 1'b1;
                        end else begin
                            ctr_d = ctr_q + CTR_W'(1);
                        end
                    end
                end
                RPT: begin
                    if (!key) begin
                        state_d = DEB_OFF;
                        ctr_d   = '0;
                    end else if (tick) begin
                        if (ctr_q == CTR_W'(C_REP_TICKS - 1)) begin
                            ctr_d = '0;
                            rep_d = 1'b1;
                        end else begin
                            ctr_d = ctr_q + CTR_W'(1);
                        end
                    end
                end
                DEB_OFF: begin
                    // Bounce during release restarts long-press timing from HELD.
                    if (key) begin
                        state_d = HELD;
                        ctr_d   = '0;
                    end else if (tick) begin
                        if (ctr_q == CTR_W'(C_DEB_TICKS - 1)) begin
                            state_d = IDLE;
                            ctr_d   = '0;
                            rel_d   = 1'b1;
                        end else begin
                            ctr_d = ctr_q + CTR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ctr_d   = '0;
                end
            endcase
        end
        lvl_d = (state_d == HELD) || (state_d == RPT) || (state_d == DEB_OFF);
    end

    assign lvl   = lvl_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign lng   = lng_q;
    assign rep   = rep_q;
    assign tog   = tog_q;
endmodule

module tm1638_key_event #(
    parameter int C_TICK_CYC   = 48_000,
    parameter int C_DEB_TICKS  = 20,
    parameter int C_LONG_TICKS = 800,
    parameter int C_REP_TICKS  = 150
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic [7:0] KEYS_i,
    input  logic       CLR_i,
    output logic [7:0] KEYS_o,
    output logic [7:0] PRESS_o,
    output logic [7:0] RELEASE_o,
    output logic [7:0] LONG_o,
    output logic [7:0] REPEAT_o,
    output logic [7:0] TOGGLE_o
);
    localparam int PRE_W = $clog2(C_TICK_CYC);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    // Free-running; CLR_i deliberately leaves the time base alone.
    assign tick  = (pre_q == PRE_W'(C_TICK_CYC - 1));
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) pre_q <= '0;
        else          pre_q <= pre_d;
    end

    for (genvar i = 0; i < 8; i++) begin : g_key
        tm1638_key_fsm #(
            .C_DEB_TICKS (C_DEB_TICKS),
            .C_LONG_TICKS(C_LONG_TICKS),
            .C_REP_TICKS (C_REP_TICKS)
        ) u_fsm (
            .clk  (CK_i),
            .rst_n(XARST_i),
            .tick (tick),
            .clr  (CLR_i),
            .key  (KEYS_i[i]),
            .lvl  (KEYS_o[i]),
            .press(PRESS_o[i]),
            .rel  (RELEASE_o[i]),
            .lng  (LONG_o[i]),
            .rep  (REPEAT_o[i]),
            .tog  (TOGGLE_o[i])
        );
    end
endmodule

// File: tb/tb_tm1638_key_event.sv
// Directed bench for tm1638_key_event with a 4-cycle tick, 3-tick debounce,
// 10-tick long press and 2-tick repeat.

module tb_tm1638_key_event;
    logic       ck = 1'b0;
    logic       xarst;
    logic [7:0] keys_i;
    logic       clr;
    logic [7:0] keys_o, press_o, release_o, long_o, repeat_o, toggle_o;

    int checks = 0;
    int errors = 0;
    int n;

    logic [7:0] acc_keys_or, acc_keys_and, acc_press, acc_rel, acc_long, acc_rep;

    tm1638_key_event #(
        .C_TICK_CYC  (4),
        .C_DEB_TICKS (3),
        .C_LONG_TICKS(10),
        .C_REP_TICKS (2)
    ) dut (
        .CK_i     (ck),
        .XARST_i  (xarst),
        .KEYS_i   (keys_i),
        .CLR_i    (clr),
        .KEYS_o   (keys_o),
        .PRESS_o  (press_o),
        .RELEASE_o(release_o),
        .LONG_o   (long_o),
        .REPEAT_o (repeat_o),
        .TOGGLE_o (toggle_o)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_acc();
        acc_keys_or  = '0;
        acc_keys_and = '1;
        acc_press    = '0;
        acc_rel      = '0;
        acc_long     = '0;
        acc_rep      = '0;
    endtask

    // Advance one cycle at a time, sampling 1 time unit after the edge.
    task automatic run(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(posedge ck);
            #1;
            acc_keys_or  |= keys_o;
            acc_keys_and &= keys_o;
            acc_press    |= press_o;
            acc_rel      |= release_o;
            acc_long     |= long_o;
            acc_rep      |= repeat_o;
        end
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            0:       return keys_o;
            1:       return press_o;
            2:       return release_o;
            3:       return long_o;
            default: return repeat_o;
        endcase
    endfunction

    // Bounded wait; cnt is maxc+1 on timeout so downstream checks fail.
    task automatic wait_bit(input int sel, input int idx, input logic val,
                            input int maxc, output int cnt);
        logic [7:0] v;
        cnt = maxc + 1;
        for (int i = 1; i <= maxc; i++) begin
            run(1);
            v = pick(sel);
            if (v[idx] === val) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        xarst  = 1'b0;
        keys_i = 8'h00;
        clr    = 1'b0;
        clr_acc();

        run(3);
        check("reset_outputs", {16'h0, keys_o, press_o, release_o, long_o, repeat_o, toggle_o}, 64'h0);
        xarst = 1'b1;
        clr_acc();
        run(10);
        check("idle_after_reset", {16'h0, acc_keys_or, acc_press, acc_rel, acc_long, acc_rep, toggle_o}, 64'h0);

        // Clean press/release on key 2.
        clr_acc();
        keys_i = 8'h04;
        wait_bit(0, 2, 1'b1, 20, n);
        check("press2_latency_in_9_12", 64'((n - 1 >= 9) && (n - 1 <= 12)), 64'h1);
        check("press2_pulse", {40'h0, press_o, keys_o, toggle_o}, {40'h0, 8'h04, 8'h04, 8'h04});
        run(1);
        check("press2_one_cycle", {56'h0, press_o}, 64'h0);
        run(40 - n - 1);
        keys_i = 8'h00;
        wait_bit(0, 2, 1'b0, 20, n);
        check("release2_latency_in_9_12", 64'((n - 1 >= 9) && (n - 1 <= 12)), 64'h1);
        check("release2_pulse", {56'h0, release_o}, 64'h04);
        check("hold2_no_long", {56'h0, acc_long}, 64'h0);
        run(1);
        check("release2_one_cycle", {56'h0, release_o}, 64'h0);

        // Short high glitch on key 0 is rejected.
        clr_acc();
        keys_i = 8'h01;
        run(7);
        keys_i = 8'h00;
        run(20);
        check("glitch_high_rejected", {48'h0, acc_keys_or, acc_press}, 64'h0);

        // Short low glitch during a hold is rejected.
        keys_i = 8'h01;
        wait_bit(1, 0, 1'b1, 20, n);
        check("press0_latency_in_9_12", 64'((n - 1 >= 9) && (n - 1 <= 12)), 64'h1);
        run(3);
        clr_acc();
        keys_i = 8'h00;
        run(7);
        keys_i = 8'h01;
        run(20);
        check("glitch_low_rejected", {48'h0, acc_rel, 7'h0, acc_keys_and[0]}, {48'h0, 8'h00, 8'h01});
        keys_i = 8'h00;
        wait_bit(2, 0, 1'b1, 20, n);
        check("release0_seen", 64'(n <= 20), 64'h1);

        // Long press and repeat on key 5.
        keys_i = 8'h20;
        wait_bit(1, 5, 1'b1, 20, n);
        check("press5_seen", 64'(n <= 20), 64'h1);
        wait_bit(3, 5, 1'b1, 60, n);
        check("long5_after_40", 64'(n), 64'd40);
        check("long5_pulse", {48'h0, long_o, repeat_o}, {48'h0, 8'h20, 8'h00});
        wait_bit(4, 5, 1'b1, 20, n);
        check("repeat5_first_8", 64'(n), 64'd8);
        wait_bit(4, 5, 1'b1, 20, n);
        check("repeat5_second_8", 64'(n), 64'd8);
        clr_acc();
        keys_i = 8'h00;
        wait_bit(2, 5, 1'b1, 20, n);
        check("release5_latency_in_9_12", 64'((n - 1 >= 9) && (n - 1 <= 12)), 64'h1);
        check("release5_no_repeat", {56'h0, acc_rep}, 64'h0);

        // Simultaneous press on keys 1 and 6.
        keys_i = 8'h42;
        wait_bit(1, 1, 1'b1, 20, n);
        check("multi_press", {48'h0, press_o, toggle_o}, {48'h0, 8'h42, 8'h67});
        keys_i = 8'h00;
        wait_bit(2, 1, 1'b1, 20, n);
        check("multi_release", {56'h0, release_o}, 64'h42);
        keys_i = 8'h02;
        wait_bit(1, 1, 1'b1, 20, n);
        check("toggle1_back", {48'h0, press_o, toggle_o}, {48'h0, 8'h02, 8'h65});
        keys_i = 8'h00;
        wait_bit(2, 1, 1'b1, 20, n);
        check("release1_seen", 64'(n <= 20), 64'h1);

        // Clear while keys 3 and 4 are held.
        keys_i = 8'h18;
        wait_bit(1, 3, 1'b1, 20, n);
        check("press34", {48'h0, press_o, toggle_o}, {48'h0, 8'h18, 8'h7D});
        run(2);
        clr = 1'b1;
        run(1);
        check("clear_outputs", {16'h0, keys_o, press_o, release_o, long_o, repeat_o, toggle_o}, 64'h0);
        clr = 1'b0;
        clr_acc();
        wait_bit(1, 3, 1'b1, 20, n);
        check("repress34_latency_in_9_12", 64'((n - 1 >= 9) && (n - 1 <= 12)), 64'h1);
        check("repress34", {48'h0, press_o, toggle_o}, {48'h0, 8'h18, 8'h18});
        check("clear_no_release", {56'h0, acc_rel}, 64'h0);

        // Asynchronous reset mid-cycle.
        #3;
        xarst = 1'b0;
        #1;
        check("async_reset_immediate", {16'h0, keys_o, press_o, release_o, long_o, repeat_o, toggle_o}, 64'h0);
        keys_i = 8'h00;
        run(2);
        xarst = 1'b1;
        clr_acc();
        run(20);
        check("idle_after_midrun_reset", {40'h0, acc_keys_or, acc_press, toggle_o}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tm1638_key_event.md
# tm1638_key_event

Per-key debounce and event generator for the 8 raw key levels produced by the TM1638 LED/key board driver (its `KEYS_o`, refreshed once per scan frame). It sits directly downstream of that driver. It turns glitchy frame-rate key levels into clean debounced levels, single-cycle press/release pulses, a long-press pulse, auto-repeat pulses and per-key toggle flags. Demo logic and user logic consume these outputs instead of edge-detecting the raw keys themselves.

## Interface
- `C_TICK_CYC`, 48_000: CK cycles per time-base tick (1 ms at 48 MHz); ≥2.
- `C_DEB_TICKS`, 20: ticks a new level must stay stable before it is accepted; ≥1.
- `C_LONG_TICKS`, 800: ticks of debounced hold before LONG fires; ≥1.
- `C_REP_TICKS`, 150: ticks between REPEAT pulses after LONG; ≥1.

Ports:
- `CK_i` in 1: the single clock for the block.
- `XARST_i` in 1: reset, asynchronous and active-low.
- `KEYS_i` in 8: raw key levels from the driver (1 = pressed), synchronous to CK_i.
- `CLR_i` in 1: synchronous clear of all key state and toggles.
- `KEYS_o` out 8: debounced levels.
- `PRESS_o` out 8: 1-cycle pulse on accepted press.
- `RELEASE_o` out 8: 1-cycle pulse on accepted release.
- `LONG_o` out 8: 1-cycle pulse when a hold reaches C_LONG_TICKS.
- `REPEAT_o` out 8: 1-cycle pulse every C_REP_TICKS after LONG while held.
- `TOGGLE_o` out 8: level that flips on every PRESS of its key.

## Operation
- Prescaler: a free-running counter 0..C_TICK_CYC-1. It produces an internal TICK on the cycle where it equals C_TICK_CYC-1, and that TICK is shared by all keys.
- Each key has its own FSM and tick counter CTR. CTR width is ceil(log2(max(C_DEB_TICKS, C_LONG_TICKS, C_REP_TICKS))), with a minimum of 1.
- FSM states and transitions. Raw-level tests have priority over TICK in every state. Every state entry clears CTR.
  - IDLE: debounced level 0. KEYS_i=1 → DEB_ON.
  - DEB_ON: KEYS_i=0 → IDLE, no pulse. On TICK: if CTR==C_DEB_TICKS-1 → HELD with PRESS; else CTR+1.
  - HELD: debounced level 1. KEYS_i=0 → DEB_OFF. On TICK: if CTR==C_LONG_TICKS-1 → RPT with LONG; else CTR+1.
  - RPT: debounced level 1. KEYS_i=0 → DEB_OFF. On TICK: if CTR==C_REP_TICKS-1 → REPEAT pulse, CTR=0; else CTR+1.
  - DEB_OFF: debounced level still 1. KEYS_i=1 → HELD, so bounce during release restarts long-press timing. On TICK: if CTR==C_DEB_TICKS-1 → IDLE with RELEASE; else CTR+1.
- PRESS also inverts that key's TOGGLE_o bit.
- All 8 keys are fully independent. Simultaneous events on different keys produce simultaneous pulses in the same cycle.
- CLR_i=1 (synchronous, highest priority after reset):
  - All FSMs go to IDLE and all outputs go to 0 on the next edge, with no RELEASE pulses.
  - The prescaler is not cleared.

## Timing
- Reset (XARST_i low, asynchronous): every FSM goes to IDLE, CTR=0, prescaler=0. KEYS_o, PRESS_o, RELEASE_o, LONG_o, REPEAT_o and TOGGLE_o are all 0.
- All outputs are registered and update on the same edge as the FSM state. PRESS_o[i] is high for exactly the cycle in which KEYS_o[i] first reads 1. RELEASE_o[i] is high for exactly the cycle in which KEYS_o[i] first reads 0.
- Debounce latency: the first TICK after entering DEB_ON/DEB_OFF arrives 1..C_TICK_CYC cycles later. Latency from a stable raw edge to the output edge is therefore (C_DEB_TICKS-1)·C_TICK_CYC+1 to C_DEB_TICKS·C_TICK_CYC cycles.
- LONG fires exactly C_LONG_TICKS TICKs after the PRESS cycle. REPEATs follow every C_REP_TICKS TICKs, i.e. exactly C_REP_TICKS·C_TICK_CYC cycles apart.
- A raw change in the same cycle as the terminal TICK wins: the transition is aborted and no pulse is generated.
- The 8-bit KEYS_i is sampled every cycle. The driver's frame-rate update is slow relative to C_TICK_CYC, so no extra synchronizer is needed.

## Test plan
- Reset and idle. Use C_TICK_CYC=4, C_DEB_TICKS=3, C_LONG_TICKS=10, C_REP_TICKS=2. Assert XARST_i low mid-run → all outputs 0 immediately. Release reset with KEYS_i=0 → outputs stay 0.
- Clean press/release. Hold KEYS_i[2] at 1 for 40 cycles, then 0.
  - KEYS_o[2] rises 9..12 cycles after the raw edge, with a 1-cycle PRESS_o[2] coincident and TOGGLE_o[2]=1.
  - On release, RELEASE_o[2] pulses 9..12 cycles after the raw falling edge.
- Bounce rejection. Pulse KEYS_i[0] high for 7 cycles, then low → no output change.
  - Repeat the test with a 7-cycle low glitch during a hold → KEYS_o[0] stays 1 and no RELEASE.
- Long press and repeat. Hold KEYS_i[5] continuously.
  - LONG_o[5] pulses exactly 40 cycles after PRESS_o[5].
  - REPEAT_o[5] then pulses every 8 cycles.
  - On release, repeats stop and RELEASE_o[5] follows.
- Multi-key and toggle. Press keys 1 and 6 on the same cycle → PRESS_o=8'h42 in a single cycle.
  - Press key 1 again → TOGGLE_o[1] returns to 0 while TOGGLE_o[6] stays 1.
- Clear. Assert CLR_i for 1 cycle while keys 3 and 4 are held and toggles are nonzero → the next cycle has all outputs 0 and no RELEASE pulses. The held keys are re-debounced and PRESS again afterwards.
